// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display sequencer: FSM encoding,
// one-hot source selects, BCD sizing and the shift-add-3 correction step.
package display_pkg;

    localparam int DATA_W      = 32;
    localparam int BCD_DIGITS  = 10;
    localparam int SHOW_DIGITS = 8;

    localparam logic [DATA_W-1:0] OVF_PATTERN = 32'h9999_9999;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LATCH   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    localparam logic [5:0] SRC_SYSCALL = 6'b000000;
    localparam logic [5:0] SRC_MEM     = 6'b000001;
    localparam logic [5:0] SRC_PC      = 6'b000010;
    localparam logic [5:0] SRC_CYCLE0  = 6'b000100;
    localparam logic [5:0] SRC_CYCLE1  = 6'b001000;
    localparam logic [5:0] SRC_CYCLE2  = 6'b010000;
    localparam logic [5:0] SRC_CYCLE3  = 6'b100000;
    localparam logic [5:0] SRC_AUTO    = 6'b111111;

    // Add 3 to every BCD digit that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_add3(input logic [4*BCD_DIGITS-1:0] b);
        logic [4*BCD_DIGITS-1:0] r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/display_sequencer_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// A start pulse loads the operand; done is high during the final shift
// cycle, after which bcd_out holds the result until the next start.
module bin2bcd_seq import display_pkg::*; (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         bin_in,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd_out
);

    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic                    run_q, run_d;

    // Load on start, then correct-and-shift once per cycle for 32 cycles.
    always_comb begin
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        run_d     = run_q;
        if (start) begin
            shift_d   = bin_in;
            bcd_d     = '0;
            bit_cnt_d = '0;
            run_d     = 1'b1;
        end else if (run_q) begin
            {bcd_d, shift_d} = {bcd_add3(bcd_q), shift_q} << 1;
            bit_cnt_d        = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
                run_d = 1'b0;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            run_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            run_q     <= run_d;
        end
    end

    assign done    = run_q && (bit_cnt_q == 5'd31);
    assign bcd_out = bcd_q;

endmodule

// File: rtl/display_sequencer.sv
// Refresh sequencer in front of the eight-digit seven-segment driver.
// Optional build macro DISPLAY_AUTO_SCAN_EN: switch[5:0]=111111 rotates
// through all seven sources every ROTATE_TICKS refreshes.
module display_sequencer import display_pkg::*; #(
    parameter int REFRESH_DIV  = 100000,
    parameter int ROTATE_TICKS = 1000
) (
    input  logic              cp,
    input  logic              rst_n,
    input  logic [6:0]        switch,
    input  logic [DATA_W-1:0] syscall_out,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] cycle0,
    input  logic [DATA_W-1:0] cycle1,
    input  logic [DATA_W-1:0] cycle2,
    input  logic [DATA_W-1:0] cycle3,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              ovf
);

    localparam logic [23:0] TICK_LAST = 24'(REFRESH_DIV - 1);

    logic [23:0]             tick_cnt_q, tick_cnt_d;
    logic                    tick;
    logic [1:0]              state_q, state_d;
    logic [DATA_W-1:0]       src_q, src_d, src_sel;
    logic                    dec_q, dec_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic                    conv_start, conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;

    // Clamp a 10-digit BCD result to the 8 displayable digits; bit 32 is ovf.
    function automatic logic [DATA_W:0] bcd_saturate(input logic [4*BCD_DIGITS-1:0] bcd);
        if (bcd[4*BCD_DIGITS-1:4*SHOW_DIGITS] != '0) begin
            return {1'b1, OVF_PATTERN};
        end
        return {1'b0, bcd[4*SHOW_DIGITS-1:0]};
    endfunction

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 24'd1;

`ifdef DISPLAY_AUTO_SCAN_EN
    localparam int ROT_W = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_TICKS - 1);

    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [2:0]        scan_q, scan_d;
    logic [DATA_W-1:0] auto_src;

    // Advance the scan index once per ROTATE_TICKS completed refreshes;
    // leaving auto-scan restarts the rotation from source 0.
    always_comb begin
        rot_d  = rot_q;
        scan_d = scan_q;
        if (switch[5:0] != SRC_AUTO) begin
            rot_d  = '0;
            scan_d = '0;
        end else if (state_q == ST_UPDATE) begin
            if (rot_q == ROT_LAST) begin
                rot_d  = '0;
                scan_d = (scan_q == 3'd6) ? 3'd0 : scan_q + 3'd1;
            end else begin
                rot_d = rot_q + ROT_W'(1);
            end
        end
    end

    // Auto-scan rotation registers.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            rot_q  <= '0;
            scan_q <= '0;
        end else begin
            rot_q  <= rot_d;
            scan_q <= scan_d;
        end
    end

    // Source picked by the current scan index.
    always_comb begin
        case (scan_q)
            3'd0:    auto_src = syscall_out;
            3'd1:    auto_src = mem;
            3'd2:    auto_src = pc;
            3'd3:    auto_src = cycle0;
            3'd4:    auto_src = cycle1;
            3'd5:    auto_src = cycle2;
            3'd6:    auto_src = cycle3;
            default: auto_src = '0;
        endcase
    end
`else
    // ROTATE_TICKS only matters when auto-scan is built in.
    localparam int unused_rotate_ticks = ROTATE_TICKS;
`endif

    // Source mux driven by the one-hot switch pattern; unknown patterns show 0.
    always_comb begin
        case (switch[5:0])
            SRC_SYSCALL: src_sel = syscall_out;
            SRC_MEM:     src_sel = mem;
            SRC_PC:      src_sel = pc;
            SRC_CYCLE0:  src_sel = cycle0;
            SRC_CYCLE1:  src_sel = cycle1;
            SRC_CYCLE2:  src_sel = cycle2;
            SRC_CYCLE3:  src_sel = cycle3;
`ifdef DISPLAY_AUTO_SCAN_EN
            SRC_AUTO:    src_sel = auto_src;
`else
            SRC_AUTO:    src_sel = '0;
`endif
            default:     src_sel = '0;
        endcase
    end

    // Refresh FSM: wait for tick, latch source, optionally convert, publish.
    // The converter is fed from the mux in the same cycle src_q captures it,
    // so both see the identical latched value.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dec_d      = dec_q;
        data_d     = data_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                src_d = src_sel;
                dec_d = switch[6];
                if (switch[6]) begin
                    conv_start = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_CONVERT;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (dec_q) begin
                    {ovf_d, data_d} = bcd_saturate(conv_bcd);
                end else begin
                    data_d = src_q;
                    ovf_d  = 1'b0;
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tick counter, FSM and output registers.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dec_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            src_q      <= src_d;
            dec_q      <= dec_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (cp),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin_in  (src_sel),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign data = data_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer with REFRESH_DIV=64, ROTATE_TICKS=2.
// Expectations are tagged with the posedge count (since reset release) after
// which they hold; a negedge monitor compares them against the outputs.
module tb_display_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  switch;
    logic [31:0] syscall_out, mem, pc, cycle0, cycle1, cycle2, cycle3;
    logic [31:0] data;
    logic        busy, ovf;

    display_sequencer #(.REFRESH_DIV(64), .ROTATE_TICKS(2)) dut (
        .cp          (clk),
        .rst_n       (rst_n),
        .switch      (switch),
        .syscall_out (syscall_out),
        .mem         (mem),
        .pc          (pc),
        .cycle0      (cycle0),
        .cycle1      (cycle1),
        .cycle2      (cycle2),
        .cycle3      (cycle3),
        .data        (data),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at_edge;
        logic [31:0] data;
        logic        ovf;
        logic        busy;
        bit          chk_data;
        bit          chk_busy;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    applied = 0;
    int    miscompares = 0;
    int    edge_n = 0;

    // Posedges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Monitor: compare the head expectation when its edge has been reached.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].at_edge == edge_n) begin
                applied++;
                if ((sb[0].chk_data && (data !== sb[0].data || ovf !== sb[0].ovf)) ||
                    (sb[0].chk_busy && busy !== sb[0].busy)) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d: got data=%h ovf=%b busy=%b, expected data=%h ovf=%b busy=%b",
                             sb_name[0], edge_n, data, ovf, busy, sb[0].data, sb[0].ovf, sb[0].busy);
                end
                void'(sb.pop_front());
                void'(sb_name.pop_front());
            end else if (sb[0].at_edge < edge_n) begin
                applied++;
                miscompares++;
                $display("FAIL %s: check edge %0d passed unsampled (now %0d)", sb_name[0], sb[0].at_edge, edge_n);
                void'(sb.pop_front());
                void'(sb_name.pop_front());
            end
        end
    end

    task automatic expect_at(input int e, input logic [31:0] d, input logic o, input logic b,
                             input bit cd, input bit cb, input string nm);
        exp_t x;
        x.at_edge = e; x.data = d; x.ovf = o; x.busy = b; x.chk_data = cd; x.chk_busy = cb;
        sb.push_back(x);
        sb_name.push_back(nm);
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (edge_n < e && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n < e) begin
            miscompares++;
            $display("FAIL wait_edge: edge %0d not reached, at %0d", e, edge_n);
        end
    endtask

    logic [31:0] auto_v [7];
    logic [31:0] exp_auto;

    initial begin
        switch = 7'b0000010;
        syscall_out = '0; mem = '0; pc = 32'h0040_1A3C;
        cycle0 = '0; cycle1 = '0; cycle2 = '0; cycle3 = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        expect_at(0, 32'h0, 1'b0, 1'b0, 1, 1, "reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Hex mode on pc: tick edge 64, update at 66.
        expect_at(30, 32'h0,         1'b0, 1'b0, 1, 1, "no_update_before_tick");
        expect_at(65, 32'h0,         1'b0, 1'b0, 1, 1, "hex_latch_cycle");
        expect_at(66, 32'h0040_1A3C, 1'b0, 1'b0, 1, 1, "hex_pc");
        expect_at(97, 32'h0040_1A3C, 1'b0, 1'b0, 1, 1, "hex_hold");

        // Decimal mode on mem: tick edge 128, busy 129..160, update at 162.
        wait_edge(100);
        switch = 7'b1000001; mem = 32'd12345678;
        expect_at(128, 32'h0040_1A3C, 1'b0, 1'b0, 1, 1, "dec_tick_edge");
        expect_at(129, 32'h0040_1A3C, 1'b0, 1'b1, 1, 1, "dec_busy_rise");
        expect_at(160, 32'h0040_1A3C, 1'b0, 1'b1, 1, 1, "dec_busy_last");
        expect_at(161, 32'h0040_1A3C, 1'b0, 1'b0, 1, 1, "dec_busy_fall");
        expect_at(162, 32'h1234_5678, 1'b0, 1'b0, 1, 1, "dec_12345678");

        // Overflow: 4294967295 saturates.
        wait_edge(170);
        switch = 7'b1000000; syscall_out = 32'hFFFF_FFFF;
        expect_at(225, 32'h1234_5678, 1'b0, 1'b0, 1, 1, "ovf_before");
        expect_at(226, 32'h9999_9999, 1'b1, 1'b0, 1, 1, "ovf_saturate");

        // 99999999 is the largest value shown without overflow.
        wait_edge(230);
        syscall_out = 32'd99999999;
        expect_at(289, 32'h9999_9999, 1'b1, 1'b0, 1, 1, "max_before");
        expect_at(290, 32'h9999_9999, 1'b0, 1'b0, 1, 1, "max_no_ovf");

        // Switch and source change during CONVERT are ignored.
        wait_edge(295);
        switch = 7'b1001000; cycle1 = 32'd7; cycle2 = 32'hCAFE_0042;
        expect_at(340, 32'h9999_9999, 1'b0, 1'b1, 1, 1, "midconv_busy");
        expect_at(354, 32'h0000_0007, 1'b0, 1'b0, 1, 1, "midconv_latched");
        expect_at(386, 32'hCAFE_0042, 1'b0, 1'b0, 1, 1, "next_tick_cycle2");
        wait_edge(330);
        switch = 7'b0010000; cycle1 = 32'd999;

        // Further hex sources, unlisted pattern, decimal cycle3.
        wait_edge(390);
        switch = 7'b0000100; cycle0 = 32'h1234_ABCD;
        expect_at(450, 32'h1234_ABCD, 1'b0, 1'b0, 1, 1, "hex_cycle0");
        wait_edge(455);
        switch = 7'b0000011;
        expect_at(514, 32'h0, 1'b0, 1'b0, 1, 1, "unlisted_pattern");
        wait_edge(520);
        switch = 7'b1100000; cycle3 = 32'd90817;
        expect_at(610, 32'h0009_0817, 1'b0, 1'b0, 1, 1, "dec_cycle3");

        // Auto-scan: refresh j shows source (j/2) mod 7, or 0 when not built.
        wait_edge(615);
        auto_v[0] = 32'hA0A0_0000; auto_v[1] = 32'hA1A1_0001; auto_v[2] = 32'hA2A2_0002;
        auto_v[3] = 32'hA3A3_0003; auto_v[4] = 32'hA4A4_0004; auto_v[5] = 32'hA5A5_0005;
        auto_v[6] = 32'hA6A6_0006;
        syscall_out = auto_v[0]; mem = auto_v[1]; pc = auto_v[2];
        cycle0 = auto_v[3]; cycle1 = auto_v[4]; cycle2 = auto_v[5]; cycle3 = auto_v[6];
        switch = 7'b0111111;
        for (int j = 0; j < 16; j++) begin
`ifdef DISPLAY_AUTO_SCAN_EN
            exp_auto = auto_v[(j / 2) % 7];
`else
            exp_auto = 32'h0;
`endif
            expect_at(640 + 64 * j + 2, exp_auto, 1'b0, 1'b0, 1, 1, $sformatf("auto_scan_%0d", j));
        end

        // Reset asserted mid-CONVERT.
        wait_edge(1605);
        switch = 7'b1000001; mem = 32'd12345678;
`ifdef DISPLAY_AUTO_SCAN_EN
        exp_auto = auto_v[0];
`else
        exp_auto = 32'h0;
`endif
        expect_at(1670, exp_auto, 1'b0, 1'b1, 1, 1, "pre_reset_busy");
        wait_edge(1680);
        #1 rst_n = 1'b0;
        expect_at(0, 32'h0, 1'b0, 1'b0, 1, 1, "reset_mid_convert");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_at(40, 32'h0,         1'b0, 1'b0, 1, 1, "post_reset_idle");
        expect_at(64, 32'h0,         1'b0, 1'b0, 1, 1, "post_reset_tick");
        expect_at(65, 32'h0,         1'b0, 1'b1, 1, 1, "post_reset_busy");
        expect_at(98, 32'h1234_5678, 1'b0, 1'b0, 1, 1, "post_reset_dec");

        wait_edge(110);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Sequencing controller in front of the eight-digit seven-segment display driver.
- Samples one of seven 32-bit display sources, selected by the board switches, at a fixed refresh rate.
- In decimal mode it runs a multi-cycle binary-to-BCD conversion (shift-add-3, one bit per clock) instead of a combinational divider chain.
- Presents a stable 32-bit digit word to the display driver and updates it only when a refresh completes.

Parameters:
- REFRESH_DIV, 100000: cp cycles between refresh ticks; legal range 40..2^24-1.
- ROTATE_TICKS, 1000: refresh ticks per source in auto-scan mode; used only with AUTO_SCAN_EN.

Ports:
- cp  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- switch  input  7  [5:0] one-hot source select, [6] decimal mode.
- syscall_out  input  32  source 0, selected by switch[5:0]=000000.
- mem  input  32  source 1, selected by 000001.
- pc  input  32  source 2, selected by 000010.
- cycle0  input  32  source 3, selected by 000100.
- cycle1  input  32  source 4, selected by 001000.
- cycle2  input  32  source 5, selected by 010000.
- cycle3  input  32  source 6, selected by 100000.
- data  output  32  eight nibble digits to the display driver.
- busy  output  1  conversion in progress.
- ovf  output  1  last decimal value exceeded 99,999,999.

Behaviour:
- Reset, asynchronous on rst_n low: data=0, busy=0, ovf=0, tick counter=0, FSM=IDLE. Internal BCD and shift registers clear.
- Tick counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick=1 for one cycle when the counter equals REFRESH_DIV-1.
  - The counter runs in every FSM state.
- FSM states: IDLE, LATCH, CONVERT, UPDATE.
- IDLE: on tick go to LATCH; otherwise stay.
- LATCH, one cycle:
  - Capture the selected source into src_q.
  - Capture switch[6] into dec_q.
  - Any unlisted switch[5:0] pattern captures 0.
  - If dec_q=0, go to UPDATE.
  - If dec_q=1, load shift=src_q, bcd(40b)=0, bit_cnt=0, busy=1, and go to CONVERT.
- CONVERT, exactly 32 cycles:
  - Each cycle, add 3 to every BCD nibble that is >=5.
  - Then shift {bcd,shift} left by 1.
  - Increment bit_cnt; after bit_cnt=31 go to UPDATE.
- UPDATE, one cycle:
  - Hex mode: data<=src_q, ovf<=0.
  - Decimal mode: if bcd[39:32]!=0 then data<=32'h99999999 and ovf<=1; otherwise data<=bcd[31:0] and ovf<=0.
  - busy<=0; return to IDLE.
- Latency from tick to data change: 2 cycles in hex mode, 34 cycles in decimal mode.
- Between updates, data holds its value.
- Switch changes outside LATCH have no effect until the next tick.
- A switch change during CONVERT does not abort the conversion; the latched value completes.
- A tick arriving while the FSM is not in IDLE is dropped. This cannot occur when REFRESH_DIV>=40.
- A source input changing during CONVERT is ignored, because src_q is frozen.
- rst_n asserted mid-CONVERT aborts immediately to the reset values; the first update after reset follows the first tick.

Optional Feature:
- Macro: DISPLAY_AUTO_SCAN_EN.
- Defined:
  - switch[5:0]=111111 selects auto-scan. A 3-bit scan index (0..6, wraps 6->0) advances every ROTATE_TICKS ticks, and LATCH captures source[scan index].
  - The scan index and rotate counter reset to 0 on rst_n, and also when auto-scan is deselected.
  - switch[6] still selects hex or decimal.
- Undefined: 111111 is an unlisted pattern and captures 0. No rotate counter is built.

Decomposition:
- Package display_pkg holds:
  - FSM state encoding (2 bits).
  - Source-select one-hot constants SRC_SYSCALL..SRC_CYCLE3.
  - Constants BCD_DIGITS=10, SHOW_DIGITS=8, OVF_PATTERN=32'h99999999.
- One sub-module, bin2bcd_seq, implements the shift-add-3 engine (start/done handshake, 32-bit in, 40-bit out).
- display_sequencer keeps the tick counter, source mux, FSM and output registers.

Test Plan (bench overrides REFRESH_DIV=64, ROTATE_TICKS=2):
- Reset: assert rst_n=0 mid-CONVERT -> data=0, busy=0, ovf=0 immediately. After release, no update occurs before the first tick.
- Hex mode: switch=7'b0000010, pc=32'h0040_1A3C -> data=32'h00401A3C exactly 2 cycles after tick; busy stays 0; ovf=0.
- Decimal mode: switch=7'b1000001, mem=32'd12345678 -> busy=1 for 32 cycles, then data=32'h12345678 at tick+34, ovf=0.
- Overflow: switch=7'b1000000, syscall_out=32'hFFFF_FFFF (4294967295) -> data=32'h99999999, ovf=1. Next conversion of 32'd99999999 -> data=32'h99999999, ovf=0.
- Mid-conversion change: start decimal on cycle1=32'd7, flip switch to 7'b0010000 during CONVERT -> the update shows 32'h00000007. The following tick shows cycle2.
- With DISPLAY_AUTO_SCAN_EN, switch=7'b0111111 -> data steps through sources 0..6 every 2 ticks, then wraps to source 0. Without the macro -> data=0.
